// File: rtl/arf_controller.sv
// arf_controller: sequences PC/SP/AR register-file operations and memory strobes; optional stack guard via ARF_CTRL_STACK_GUARD_EN
module arf_controller #(
    parameter int STACK_DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_data,
    output logic        req_ready,
    output logic        done,
    output logic        err,
    output logic [31:0] arf_i,
    output logic [2:0]  arf_regsel,
    output logic [1:0]  arf_funsel,
    output logic [1:0]  arf_outasel,
    output logic [1:0]  arf_outbsel,
    output logic        mem_rd,
    output logic        mem_wr
);
    typedef enum logic [2:0] {IDLE, PRE, SEL, ACCESS, UPDATE, DONE} state_t;
    localparam logic [2:0] OP_FETCH = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_JUMP  = 3'b011;
    localparam logic [2:0] OP_LDAR  = 3'b100;
    localparam logic [2:0] OP_LDSP  = 3'b101;
    localparam logic [2:0] OP_CLR   = 3'b110;
    localparam logic [2:0] OP_ILL   = 3'b111;

    state_t      state, state_next;
    logic [2:0]  op_q;
    logic [15:0] data_q;
    logic        err_q;
    logic        reject;
    logic        accept;

    assign accept = req_valid && state == IDLE;

`ifdef ARF_CTRL_STACK_GUARD_EN
    localparam int DW = $clog2(STACK_DEPTH + 1);
    logic [DW-1:0] depth;
    assign reject = (req_op == OP_PUSH && depth == DW'(STACK_DEPTH)) ||
                    (req_op == OP_POP && depth == '0);
    // depth tracks SP movement in the same cycle the register file is told to move it
    always_ff @(posedge clock) begin
        if (reset)
            depth <= '0;
        else if (state == PRE)
            depth <= depth - 1'b1;
        else if (state == UPDATE && op_q == OP_PUSH)
            depth <= depth + 1'b1;
        else if (state == UPDATE && (op_q == OP_LDSP || op_q == OP_CLR))
            depth <= '0;
    end
`else
    logic unused_depth;
    assign unused_depth = STACK_DEPTH[0];
    assign reject = 1'b0;
`endif

    // state register
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // request capture; inputs are ignored after acceptance
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= OP_FETCH;
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            op_q   <= req_op;
            data_q <= req_data;
            err_q  <= req_op == OP_ILL || reject;
        end
    end

    // next-state: POP pre-increments SP, FETCH/PUSH need SEL so OutC is valid in ACCESS
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid)
                         state_next = (req_op == OP_ILL || reject) ? DONE :
                                      (req_op == OP_POP) ? PRE :
                                      (req_op == OP_FETCH || req_op == OP_PUSH) ? SEL : UPDATE;
            PRE:     state_next = SEL;
            SEL:     state_next = ACCESS;
            ACCESS:  state_next = (op_q == OP_POP) ? DONE : UPDATE;
            UPDATE:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // outputs decoded from state and captured op
    always_comb begin
        req_ready   = state == IDLE;
        done        = state == DONE;
        err         = state == DONE && err_q;
        arf_i       = {16'h0000, data_q};
        arf_regsel  = 3'b000;
        arf_funsel  = 2'b00;
        arf_outasel = (state == SEL || state == ACCESS) && (op_q == OP_PUSH || op_q == OP_POP) ? 2'b01 : 2'b00;
        mem_rd      = state == ACCESS && op_q != OP_PUSH;
        mem_wr      = state == ACCESS && op_q == OP_PUSH;
        if (state == PRE) begin
            arf_regsel = 3'b010;
            arf_funsel = 2'b01;
        end else if (state == UPDATE) begin
            arf_regsel = (op_q == OP_FETCH || op_q == OP_JUMP) ? 3'b001 :
                         (op_q == OP_PUSH || op_q == OP_LDSP) ? 3'b010 :
                         (op_q == OP_LDAR) ? 3'b100 :
                         (op_q == OP_CLR) ? 3'b111 : 3'b000;
            arf_funsel = (op_q == OP_FETCH) ? 2'b01 :
                         (op_q == OP_PUSH) ? 2'b00 :
                         (op_q == OP_CLR) ? 2'b11 : 2'b10;
        end
        arf_outbsel = arf_outasel;
    end
endmodule

// File: tb/tb_arf_controller.sv
// tb_arf_controller: directed vector table plus reset, back-to-back and stack-guard sequences
module tb_arf_controller;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [15:0] req_data;
    logic        req_ready, done, err, mem_rd, mem_wr;
    logic [31:0] arf_i;
    logic [2:0]  arf_regsel;
    logic [1:0]  arf_funsel, arf_outasel, arf_outbsel;

    int total = 0;
    int bad = 0;

    arf_controller #(.STACK_DEPTH(256)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_data(req_data), .req_ready(req_ready), .done(done), .err(err),
        .arf_i(arf_i), .arf_regsel(arf_regsel), .arf_funsel(arf_funsel),
        .arf_outasel(arf_outasel), .arf_outbsel(arf_outbsel),
        .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    always #5 clock = ~clock;

    // control word: {regsel[2:0], funsel[1:0], outasel[1:0], mem_rd, mem_wr}
    typedef struct {
        logic [2:0]      op;
        logic [15:0]     data;
        int              n;
        logic            e;
        logic [3:0][8:0] c;
        string           name;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [2:0] op, input logic [15:0] data, input int n, input logic e,
                                input logic [8:0] c1, c2, c3, c4, input string name);
        vec_t v;
        v.op = op; v.data = data; v.n = n; v.e = e; v.c = {c4, c3, c2, c1}; v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] ctrl();
        return {arf_regsel, arf_funsel, arf_outasel, mem_rd, mem_wr};
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // issue a request and report the cycle of done and err; bounded wait
    task automatic do_req(input logic [2:0] op, input logic [15:0] data, output int cyc, output logic e);
        req_valid = 1'b1; req_op = op; req_data = data;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        cyc = 0; e = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (done) begin
                cyc = k; e = err;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
    endtask

    initial begin
        int cyc;
        logic e;
        reset = 1'b1; req_valid = 1'b0; req_op = 3'b000; req_data = 16'h0;
        vecs[0] = mk(3'b000, 16'h0000, 4, 1'b0, 9'b000000000, 9'b000000010, 9'b001010000, 9'b000000000, "fetch");
        vecs[1] = mk(3'b011, 16'h1234, 2, 1'b0, 9'b001100000, 9'b000000000, 9'b0, 9'b0, "jump");
        vecs[2] = mk(3'b001, 16'hAAAA, 4, 1'b0, 9'b000000100, 9'b000000101, 9'b010000000, 9'b000000000, "push");
        vecs[3] = mk(3'b010, 16'h5555, 4, 1'b0, 9'b010010000, 9'b000000100, 9'b000000110, 9'b000000000, "pop");
        vecs[4] = mk(3'b100, 16'hBEEF, 2, 1'b0, 9'b100100000, 9'b000000000, 9'b0, 9'b0, "load_ar");
        vecs[5] = mk(3'b101, 16'h0F0F, 2, 1'b0, 9'b010100000, 9'b000000000, 9'b0, 9'b0, "load_sp");
        vecs[6] = mk(3'b110, 16'h7777, 2, 1'b0, 9'b111110000, 9'b000000000, 9'b0, 9'b0, "clear");
        vecs[7] = mk(3'b111, 16'hC0DE, 1, 1'b1, 9'b000000000, 9'b0, 9'b0, 9'b0, "illegal");

        do_reset();
        chk("reset_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_ctrl", {23'b0, ctrl()}, 32'd0);
        chk("reset_done_err", {30'b0, done, err}, 32'd0);
        chk("reset_arf_i", arf_i, 32'd0);
        chk("reset_outb", {30'b0, arf_outbsel}, 32'd0);

        foreach (vecs[i]) begin
            req_valid = 1'b1; req_op = vecs[i].op; req_data = vecs[i].data;
            @(posedge clock);
            @(negedge clock);
            req_valid = 1'b0; req_op = 3'b111; req_data = 16'hFFFF;
            for (int k = 1; k <= vecs[i].n; k++) begin
                chk($sformatf("%s_c%0d_ctrl", vecs[i].name, k), {23'b0, ctrl()}, {23'b0, vecs[i].c[k-1]});
                chk($sformatf("%s_c%0d_done", vecs[i].name, k), {31'b0, done}, {31'b0, k == vecs[i].n});
                chk($sformatf("%s_c%0d_err", vecs[i].name, k), {31'b0, err}, {31'b0, k == vecs[i].n && vecs[i].e});
                chk($sformatf("%s_c%0d_ready", vecs[i].name, k), {31'b0, req_ready}, 32'd0);
                chk($sformatf("%s_c%0d_arf_i", vecs[i].name, k), arf_i, {16'h0, vecs[i].data});
                chk($sformatf("%s_c%0d_outb", vecs[i].name, k), {30'b0, arf_outbsel}, {30'b0, arf_outasel});
                @(negedge clock);
            end
            chk($sformatf("%s_idle_ready", vecs[i].name), {31'b0, req_ready}, 32'd1);
            chk($sformatf("%s_idle_done", vecs[i].name), {31'b0, done}, 32'd0);
        end

        // reset during ACCESS of FETCH
        req_valid = 1'b1; req_op = 3'b000; req_data = 16'h0;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        chk("rst_mid_access_rd", {31'b0, mem_rd}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_mid_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mid_ctrl", {23'b0, ctrl()}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("rst_mid_no_done", {31'b0, done}, 32'd0);
            @(negedge clock);
        end

        // back-to-back FETCH with req_valid held: dones at cycles 4 and 9
        req_valid = 1'b1; req_op = 3'b000;
        @(posedge clock);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            chk($sformatf("b2b_done_c%0d", k), {31'b0, done}, {31'b0, k == 4 || k == 9});
            if (k == 5) chk("b2b_ready_c5", {31'b0, req_ready}, 32'd1);
        end
        req_valid = 1'b0;
        @(negedge clock);

`ifdef ARF_CTRL_STACK_GUARD_EN
        do_reset();
        do_req(3'b010, 16'h0, cyc, e);
        chk("guard_pop_empty_cyc", cyc, 32'd1);
        chk("guard_pop_empty_err", {31'b0, e}, 32'd1);
        for (int p = 0; p < 256; p++) begin
            do_req(3'b001, 16'h0, cyc, e);
            if (p == 255) begin
                chk("guard_push256_cyc", cyc, 32'd4);
                chk("guard_push256_err", {31'b0, e}, 32'd0);
            end
        end
        req_valid = 1'b1; req_op = 3'b001;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        chk("guard_push257_done", {31'b0, done}, 32'd1);
        chk("guard_push257_err", {31'b0, err}, 32'd1);
        chk("guard_push257_ctrl", {23'b0, ctrl()}, 32'd0);
        @(negedge clock);
`else
        do_reset();
        do_req(3'b010, 16'h0, cyc, e);
        chk("noguard_pop_cyc", cyc, 32'd4);
        chk("noguard_pop_err", {31'b0, e}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
